// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS E-stage multiply/divide unit: op codes,
// FSM states and default latencies.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 16;

endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned divider: quotient truncates toward zero,
// remainder follows the dividend sign; x/0 and min_int/-1 handled explicitly.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic [WIDTH-1:0] uq_s;
  logic [WIDTH-1:0] ur_s;
  logic [WIDTH-1:0] min_int_s;

  assign min_int_s = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_neg_s   = signed_i & a_i[WIDTH-1];
  assign b_neg_s   = signed_i & b_i[WIDTH-1];
  assign abs_a_s   = a_neg_s ? (~a_i + WIDTH'(1)) : a_i;
  // Divisor of zero is forced to one so the unused divide never yields X.
  assign abs_b_s   = (b_i == {WIDTH{1'b0}}) ? WIDTH'(1) :
                     (b_neg_s ? (~b_i + WIDTH'(1)) : b_i);
  assign uq_s      = abs_a_s / abs_b_s;
  assign ur_s      = abs_a_s % abs_b_s;

  // Result select with the architectural corner cases first.
  always_comb begin
    quo_o = uq_s;
    rem_o = ur_s;
    if (b_i == {WIDTH{1'b0}}) begin
      quo_o = {WIDTH{1'b1}};
      rem_o = a_i;
    end else if (signed_i && (a_i == min_int_s) && (b_i == {WIDTH{1'b1}})) begin
      quo_o = min_int_s;
      rem_o = {WIDTH{1'b0}};
    end else begin
      quo_o = (a_neg_s ^ b_neg_s) ? (~uq_s + WIDTH'(1)) : uq_s;
      rem_o = a_neg_s ? (~ur_s + WIDTH'(1)) : ur_s;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Optional flush input is
// enabled by defining MDU_CANCEL_EN.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic               cancel_s;
  logic               is_mul_s, is_div_s, op_signed_s;
  logic [2*WIDTH-1:0] ext_a_s, ext_b_s, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

`ifdef MDU_CANCEL_EN
  assign cancel_s = cancel;
`else
  assign cancel_s = 1'b0;
`endif

  assign is_mul_s    = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign is_div_s    = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  assign op_signed_s = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);

  assign ext_a_s = {{WIDTH{op_signed_s & rs_data[WIDTH-1]}}, rs_data};
  assign ext_b_s = {{WIDTH{op_signed_s & rt_data[WIDTH-1]}}, rt_data};
  assign prod_s  = ext_a_s * ext_b_s;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .a_i      (rs_data),
    .b_i      (rt_data),
    .signed_i (op_signed_s),
    .quo_o    (quo_s),
    .rem_o    (rem_s)
  );

  // Next-state: launch into shadow regs, count down, commit at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (cancel_s) begin
          state_d = ST_IDLE;
        end else if (start && is_mul_s) begin
          state_d = ST_MUL;
          cnt_d   = CNT_W'(MULT_CYCLES - 1);
          sh_hi_d = prod_s[2*WIDTH-1:WIDTH];
          sh_lo_d = prod_s[WIDTH-1:0];
        end else if (start && is_div_s) begin
          state_d = ST_DIV;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
          sh_hi_d = rem_s;
          sh_lo_d = quo_s;
        end else if (mdu_op == OP_MTHI) begin
          hi_d = rs_data;
        end else if (mdu_op == OP_MTLO) begin
          lo_d = rs_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cancel_s) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          sh_hi_d = {WIDTH{1'b0}};
          sh_lo_d = {WIDTH{1'b0}};
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      sh_hi_q <= {WIDTH{1'b0}};
      sh_lo_q <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // mfhi/mflo read straight from the architectural registers.
  always_comb begin
    case (mdu_op)
      OP_MFHI: rd_data = hi_q;
      OP_MFLO: rd_data = lo_q;
      default: rd_data = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit; a second instance with
// single-cycle latency covers the N=1 commit timing.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data, rt_data;
  logic        busy, busy1;
  logic [31:0] hi, lo, rd_data, hi1, lo1, rd1;
`ifdef MDU_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_unit dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy1), .hi(hi1), .lo(lo1), .rd_data(rd1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Launch one op, count busy cycles, then check HI/LO on both instances.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el);
    int cyc;
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    chk({tag, "_busy1_on"}, {31'd0, busy1}, 32'd1);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, "_busy1_off"}, {31'd0, busy1}, 32'd0);
        chk({tag, "_hi1"}, hi1, eh);
        chk({tag, "_lo1"}, lo1, el);
      end
    end
    chk({tag, "_cycles"}, cyc, n);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_data = 32'd0; rt_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    mdu_op = 4'd5;
    #1 chk("rst_rd", rd_data, 32'd0);
    mdu_op = 4'd0;
    reset = 1'b0;

    run_op("mult_neg",  4'd1, 32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu",     4'd2, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE);
    run_op("mult_nn",   4'd1, 32'hFFFFFFFD, 32'hFFFFFFFB, 5,  32'h00000000, 32'h0000000F);
    run_op("mult_big",  4'd1, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000);
    run_op("div_neg",   4'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb",  4'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",      4'd4, 32'hFFFFFFF9, 32'h00000002, 10, 32'h00000001, 32'h7FFFFFFC);
    run_op("divu_zero", 4'd4, 32'h00000007, 32'h00000000, 10, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_zero",  4'd3, 32'hFFFFFFFB, 32'h00000000, 10, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf",   4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

    // mthi/mtlo while idle, then mfhi/mflo reads
    @(negedge clk); mdu_op = 4'd7; rs_data = 32'h00001234;
    @(negedge clk); mdu_op = 4'd5;
    chk("mthi_hi", hi, 32'h00001234);
    #1 chk("mfhi_rd", rd_data, 32'h00001234);
    mdu_op = 4'd8; rs_data = 32'h00000055;
    @(negedge clk); mdu_op = 4'd6;
    #1 chk("mflo_rd", rd_data, 32'h00000055);
    mdu_op = 4'd0;
    #1 chk("mfnone_rd", rd_data, 32'h00000000);

    // div 100/7 with an mthi and a second start injected while busy
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd3; rs_data = 32'd100; rt_data = 32'd7;
    cyc = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (k == 0) begin
        start = 1'b0; mdu_op = 4'd0;
      end else if (k == 2) begin
        mdu_op = 4'd7; rs_data = 32'h0000DEAD;
      end else if (k == 3) begin
        start = 1'b1; mdu_op = 4'd1; rs_data = 32'd3; rt_data = 32'd3;
      end else if (k == 4) begin
        start = 1'b0; mdu_op = 4'd0;
      end
    end
    chk("ign_cycles", cyc, 32'd10);
    chk("ign_hi", hi, 32'd2);
    chk("ign_lo", lo, 32'd14);

    // reset in cycle 3 of a div: immediate clear, no later commit
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd3; rs_data = 32'd50; rt_data = 32'd5;
    @(negedge clk); start = 1'b0; mdu_op = 4'd0;
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
